// File: rtl/jackpot_arcade_if.sv
// jackpot_arcade_if: board-side bundle between the DIP switches, LEDs and score
// display and the jackpot_arcade game core.
//   SWITCHES  : raw DIP switch levels (asynchronous to the game clock)
//   LEDS      : LED drive
//   SCORE     : current unsigned score
//   WIN_PULSE : one-clock pulse per win
// modport master : board / testbench side (drives SWITCHES)
// modport slave  : game core side (drives LEDS, SCORE, WIN_PULSE)
interface jackpot_arcade_if #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned SCORE_W  = 8
);
    logic [NUM_LEDS-1:0] SWITCHES;
    logic [NUM_LEDS-1:0] LEDS;
    logic [SCORE_W-1:0]  SCORE;
    logic                WIN_PULSE;

    modport master (
        output SWITCHES,
        input  LEDS,
        input  SCORE,
        input  WIN_PULSE
    );

    modport slave (
        input  SWITCHES,
        output LEDS,
        output SCORE,
        output WIN_PULSE
    );
endinterface

// File: rtl/jackpot_arcade.sv
// jackpot_arcade: N-LED reflex game. A lit LED sweeps once per game tick; a fresh
// 0->1 edge on the switch under the lit LED wins (score +1, blink sequence), an
// edge on any other switch is a miss (score -1). Score saturates at both ends.
// All logic runs on CLOCK and is qualified by an internal tick strobe.
//
// Ports:
//   CLOCK : system clock (only clock)
//   RESET : asynchronous, active-high reset
//   bus   : jackpot_arcade_if.slave (SWITCHES in, LEDS/SCORE/WIN_PULSE out)
//
// Build option:
//   JACKPOT_BOUNCE_EN : when defined, the sweep ping-pongs between the end LEDs
//                       instead of wrapping from the last LED back to LED 0.
module jackpot_arcade #(
    parameter int unsigned NUM_LEDS      = 4,
    parameter int unsigned TICK_DIV      = 12_500_000,
    parameter int unsigned JACKPOT_TICKS = 4,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic            CLOCK,
    input  logic            RESET,
    jackpot_arcade_if.slave bus
);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned JK_W   = (JACKPOT_TICKS > 1) ? $clog2(JACKPOT_TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LEDS - 1);
    localparam logic [JK_W-1:0]   JK_LAST   = JK_W'(JACKPOT_TICKS - 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_JACKPOT = 1'b1
    } state_t;

    // One-hot LED pattern for a sweep position.
    function automatic logic [NUM_LEDS-1:0] decode(input logic [IDX_W-1:0] i);
        return NUM_LEDS'(1) << i;
    endfunction

    logic [NUM_LEDS-1:0] sw_meta_q;
    logic [NUM_LEDS-1:0] sw_sync_q;
    logic [NUM_LEDS-1:0] sw_prev_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [JK_W-1:0]     jk_cnt_q;
    logic [NUM_LEDS-1:0] leds_q;
    logic [SCORE_W-1:0]  score_q;
    logic                win_pulse_q;

    logic                tick_c;
    logic [NUM_LEDS-1:0] rise_c;
    logic                win_c;
    logic                miss_c;

`ifdef JACKPOT_BOUNCE_EN
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    logic dir_q;
    logic dir_d;
`endif

    // Two-flop switch synchroniser and free-running tick divider.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            sw_meta_q  <= bus.SWITCHES;
            sw_sync_q  <= sw_meta_q;
            tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    assign tick_c = (tick_cnt_q == TICK_LAST);
    assign rise_c = sw_sync_q & ~sw_prev_q;
    assign win_c  = |(rise_c & decode(idx_q));
    assign miss_c = |(rise_c & ~decode(idx_q));

`ifdef JACKPOT_BOUNCE_EN
    // Ping-pong sweep: direction flips on the step that lands on an end LED.
    always_comb begin
        idx_d = idx_q;
        dir_d = dir_q;
        if (dir_q == DIR_UP) begin
            if (idx_q != IDX_LAST) begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_d == IDX_LAST) begin
                    dir_d = DIR_DOWN;
                end
            end
        end else if (idx_q != '0) begin
            idx_d = idx_q - IDX_W'(1);
            if (idx_d == '0) begin
                dir_d = DIR_UP;
            end
        end
    end
`else
    // Wrapping sweep 0..NUM_LEDS-1.
    always_comb begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
`endif

    // Game state machine; LEDS/SCORE/WIN_PULSE are loaded with their next values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            sw_prev_q   <= '0;
            idx_q       <= '0;
            jk_cnt_q    <= '0;
            leds_q      <= NUM_LEDS'(1);
            score_q     <= '0;
            win_pulse_q <= 1'b0;
`ifdef JACKPOT_BOUNCE_EN
            dir_q       <= DIR_UP;
`endif
        end else begin
            win_pulse_q <= 1'b0;
            if (tick_c) begin
                // Edges seen during the blink are consumed here as well.
                sw_prev_q <= sw_sync_q;
                case (state_q)
                    ST_RUN: begin
                        if (win_c) begin
                            state_q     <= ST_JACKPOT;
                            jk_cnt_q    <= '0;
                            leds_q      <= '1;
                            win_pulse_q <= 1'b1;
                            if (score_q != {SCORE_W{1'b1}}) begin
                                score_q <= score_q + SCORE_W'(1);
                            end
                        end else begin
                            if (miss_c && (score_q != '0)) begin
                                score_q <= score_q - SCORE_W'(1);
                            end
                            idx_q  <= idx_d;
                            leds_q <= decode(idx_d);
`ifdef JACKPOT_BOUNCE_EN
                            dir_q  <= dir_d;
`endif
                        end
                    end
                    ST_JACKPOT: begin
                        jk_cnt_q <= jk_cnt_q + JK_W'(1);
                        if (jk_cnt_q == JK_LAST) begin
                            state_q <= ST_RUN;
                            idx_q   <= '0;
                            leds_q  <= NUM_LEDS'(1);
`ifdef JACKPOT_BOUNCE_EN
                            dir_q   <= DIR_UP;
`endif
                        end else begin
                            // Next count's bit 0 is the inverse of the current one.
                            leds_q <= {NUM_LEDS{jk_cnt_q[0]}};
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                        leds_q  <= NUM_LEDS'(1);
                    end
                endcase
            end
        end
    end

    assign bus.LEDS      = leds_q;
    assign bus.SCORE     = score_q;
    assign bus.WIN_PULSE = win_pulse_q;
endmodule

// File: tb/tb_jackpot_arcade.sv
// tb_jackpot_arcade: scoreboard bench for jackpot_arcade (default build, wrapping
// sweep). Stimulus queues the expected LEDS/SCORE/WIN_PULSE for each game tick;
// a monitor pops one entry in the cycle after every tick and checks that the
// outputs then hold (WIN_PULSE low) for the rest of the tick period.
module tb_jackpot_arcade;
    localparam int unsigned NUM_LEDS      = 4;
    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned JACKPOT_TICKS = 4;
    localparam int unsigned SCORE_W       = 2;

    typedef struct packed {
        logic [3:0] leds;
        logic [1:0] score;
        logic       win;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jackpot_arcade_if #(.NUM_LEDS(NUM_LEDS), .SCORE_W(SCORE_W)) bus ();

    jackpot_arcade #(
        .NUM_LEDS     (NUM_LEDS),
        .TICK_DIV     (TICK_DIV),
        .JACKPOT_TICKS(JACKPOT_TICKS),
        .SCORE_W      (SCORE_W)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    exp_t        last;
    int          total = 0;
    int          bad   = 0;
    int unsigned n;

    // Bench-side count of clock edges since reset release; ticks land on multiples of TICK_DIV.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pop on the cycle after each tick, otherwise check the pattern holds.
    always @(negedge clk) begin
        if (rst) begin
            last.leds  = 4'b0001;
            last.score = 2'd0;
            last.win   = 1'b0;
        end else if (n != 0) begin
            if (n % TICK_DIV == 0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL queue_underflow: no expectation queued for tick at %0t", $time);
                end else begin
                    last = exp_q.pop_front();
                    check("tick_leds",  32'(bus.LEDS),      32'(last.leds));
                    check("tick_score", 32'(bus.SCORE),     32'(last.score));
                    check("tick_win",   32'(bus.WIN_PULSE), 32'(last.win));
                end
            end else begin
                check("dwell_leds",  32'(bus.LEDS),      32'(last.leds));
                check("dwell_score", 32'(bus.SCORE),     32'(last.score));
                check("dwell_win",   32'(bus.WIN_PULSE), 32'(1'b0));
            end
        end
    end

    // Drive switches early in a tick period, queue the outcome of the coming tick,
    // and return just after the monitor has consumed it.
    task automatic step(input logic [3:0] sw, input logic [3:0] leds,
                        input logic [1:0] score, input logic win);
        exp_t e;
        e.leds  = leds;
        e.score = score;
        e.win   = win;
        bus.SWITCHES = sw;
        exp_q.push_back(e);
        do @(negedge clk); while (n % TICK_DIV != 0);
        #1;
    endtask

    // One scoring lap: release, approach LED 2, hit it, then the four-tick blink.
    task automatic win_lap(input logic [1:0] s_before, input logic [1:0] s_after);
        step(4'b0000, 4'b0010, s_before, 1'b0);
        step(4'b0000, 4'b0100, s_before, 1'b0);
        step(4'b0100, 4'b1111, s_after,  1'b1);
        step(4'b0100, 4'b0000, s_after,  1'b0);
        step(4'b0100, 4'b1111, s_after,  1'b0);
        step(4'b0100, 4'b0000, s_after,  1'b0);
        step(4'b0100, 4'b0001, s_after,  1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.SWITCHES = 4'b0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_leds",  32'(bus.LEDS),      32'(4'b0001));
        check("reset_score", 32'(bus.SCORE),     32'(2'd0));
        check("reset_win",   32'(bus.WIN_PULSE), 32'(1'b0));

        // Idle sweep
        step(4'b0000, 4'b0010, 2'd0, 1'b0);
        step(4'b0000, 4'b0100, 2'd0, 1'b0);
        step(4'b0000, 4'b1000, 2'd0, 1'b0);
        step(4'b0000, 4'b0001, 2'd0, 1'b0);

        // Win on LED 2 and blink
        win_lap(2'd0, 2'd1);

        // Held switch: no new edge, no win
        step(4'b0100, 4'b0010, 2'd1, 1'b0);
        step(4'b0100, 4'b0100, 2'd1, 1'b0);
        step(4'b0100, 4'b1000, 2'd1, 1'b0);
        step(4'b0100, 4'b0001, 2'd1, 1'b0);

        // Fresh edges: score climbs to 3 and saturates
        win_lap(2'd1, 2'd2);
        win_lap(2'd2, 2'd3);
        win_lap(2'd3, 2'd3);

        // Misses on switch 3 while LED 0 is lit: 3 -> 2 -> 1
        step(4'b1100, 4'b0010, 2'd2, 1'b0);
        step(4'b0000, 4'b0100, 2'd2, 1'b0);
        step(4'b0000, 4'b1000, 2'd2, 1'b0);
        step(4'b0000, 4'b0001, 2'd2, 1'b0);
        step(4'b1000, 4'b0010, 2'd1, 1'b0);
        // Miss at score 1 -> 0, then saturate at 0
        step(4'b0000, 4'b0100, 2'd1, 1'b0);
        step(4'b0000, 4'b1000, 2'd1, 1'b0);
        step(4'b0000, 4'b0001, 2'd1, 1'b0);
        step(4'b1000, 4'b0010, 2'd0, 1'b0);
        step(4'b0000, 4'b0100, 2'd0, 1'b0);
        step(4'b0000, 4'b1000, 2'd0, 1'b0);
        step(4'b0000, 4'b0001, 2'd0, 1'b0);
        step(4'b1000, 4'b0010, 2'd0, 1'b0);

        // Simultaneous hit on 0 and miss on 3: win only
        step(4'b0000, 4'b0100, 2'd0, 1'b0);
        step(4'b0000, 4'b1000, 2'd0, 1'b0);
        step(4'b0000, 4'b0001, 2'd0, 1'b0);
        step(4'b1001, 4'b1111, 2'd1, 1'b1);
        step(4'b1001, 4'b0000, 2'd1, 1'b0);
        step(4'b1001, 4'b1111, 2'd1, 1'b0);

        // Reset mid-blink while LEDS=1111: immediate, asynchronous
        rst = 1'b1;
        bus.SWITCHES = 4'b0000;
        #1;
        check("midreset_leds",  32'(bus.LEDS),      32'(4'b0001));
        check("midreset_score", 32'(bus.SCORE),     32'(2'd0));
        check("midreset_win",   32'(bus.WIN_PULSE), 32'(1'b0));
        check("midreset_queue", 32'(exp_q.size()),  32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // First tick TICK_DIV cycles after release, then a normal sweep
        step(4'b0000, 4'b0010, 2'd0, 1'b0);
        step(4'b0000, 4'b0100, 2'd0, 1'b0);
        step(4'b0000, 4'b1000, 2'd0, 1'b0);
        step(4'b0000, 4'b0001, 2'd0, 1'b0);

        @(negedge clk);
        #1;
        check("final_queue", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jackpot_arcade.md
# jackpot_arcade

Parametrised successor to the single-game LED jackpot: an N-LED reflex game with an on-chip tick enable instead of a derived clock, synchronised switch inputs, and edge-qualified hits. A hit scores, a mistimed press costs a point, and a win plays a blink sequence. It sits directly between the board DIP switches and LEDs, and its score can be exposed on a display.

## Interface
- `NUM_LEDS`, default 4: number of LEDs and switches, legal range 1..16.
- `TICK_DIV`, default 12_500_000: CLOCK cycles per game tick (10 Hz at 125 MHz), must be at least 2.
- `JACKPOT_TICKS`, default 4: length of the win blink sequence in ticks, must be at least 1.
- `SCORE_W`, default 8: width of the score counter.
- `CLOCK` in, 1: 125 MHz system clock. This is the only clock.
- `RESET` in, 1: asynchronous, active-high reset.
- `SWITCHES` in, NUM_LEDS: raw DIP switches, asynchronous to CLOCK.
- `LEDS` out, NUM_LEDS: LED drive.
- `SCORE` out, SCORE_W: current score, unsigned.
- `WIN_PULSE` out, 1: one-CLOCK pulse on each win.

## Operation
- **Switch synchroniser:** two flip-flops per bit produce `sw_sync`.
- **Tick generator:**
  - `tick_cnt` counts 0..TICK_DIV-1 and wraps.
  - `tick` is a one-cycle strobe when `tick_cnt` equals TICK_DIV-1.
  - All game logic is clocked by CLOCK and qualified by `tick`. There are no derived clocks.
- **Edge capture:** on every tick, in both states, `sw_prev <= sw_sync`. `rise = sw_sync & ~sw_prev`.
- **State machine:** states RUN and JACKPOT, with registers `idx`, `dir` and `jk_cnt`.
- **RUN:** LEDS is the one-hot decode of `idx`. On each tick, check in this order:
  1. Win, when `rise[idx]` is 1:
     - go to JACKPOT with `jk_cnt` = 0;
     - SCORE increments, saturating at 2^SCORE_W-1;
     - WIN_PULSE is 1 for one cycle.
  2. Miss, when any other bit of `rise` is 1 and there is no win:
     - SCORE decrements, saturating at 0;
     - `idx` advances normally.
  3. Otherwise `idx` advances:
     - without bounce, idx goes 0..NUM_LEDS-1 and wraps to 0;
     - with bounce, see Configuration.
- **Priority:** a simultaneous win and miss counts as a win only, so SCORE increases by exactly 1.
- **No hit from a held switch:** a switch held high does not hit again. A new 0→1 edge between ticks is required.
- **JACKPOT:**
  - LEDS is all ones when `jk_cnt[0]` is 0 and all zeros when it is 1.
  - Switches are ignored, but `sw_prev` still updates on each tick, so edges that occur during the blink are consumed.
  - On each tick, `jk_cnt` increments.
  - On the tick where `jk_cnt` equals JACKPOT_TICKS-1, go to RUN with `idx` = 0 and `dir` = up.
- **Reset values:**
  - Outputs: LEDS = 1 (bit 0 lit, RUN, `idx` 0), SCORE = 0, WIN_PULSE = 0.
  - Internal: `tick_cnt` = 0, synchroniser and `sw_prev` = 0, `dir` = up, `jk_cnt` = 0.
- **Reset mid-game:** asserting RESET in any state, including during JACKPOT, forces the reset values immediately and asynchronously. Score is lost.

## Timing
- **First tick:** occurs on the TICK_DIV-th rising edge of CLOCK after RESET deasserts.
- **Tick spacing:** every TICK_DIV cycles after that.
- **Switch latency:** 2 cycles from a SWITCHES change to `sw_sync`. An edge must be present in `sw_sync` at the tick cycle to count.
- **Output update:** LEDS, SCORE and WIN_PULSE are registered. They change on the clock edge that samples `tick`, i.e. they are visible in the cycle after the strobe, and they are glitch-free.
- **Tick dwell:** the LED pattern holds for exactly TICK_DIV cycles per tick.
- **Blink length:** JACKPOT lasts exactly JACKPOT_TICKS ticks.
- **NUM_LEDS = 1:** `idx` stays 0. Every edge on bit 0 at a tick is a win.

## Configuration
- **With `JACKPOT_BOUNCE_EN` defined:**
  - the sweep ping-pongs, e.g. 0,1,…,N-1,N-2,…,0,1,…;
  - `dir` flips on the tick that reaches either end, so each end LED is lit for one tick only;
  - with NUM_LEDS = 1, `idx` stays 0;
  - with NUM_LEDS = 2, the sequence is 0,1,0,1.
- **Without `JACKPOT_BOUNCE_EN`:** the sweep wraps N-1→0, and the `dir` register is not built.

## Test plan
Bench parameters: NUM_LEDS=4, TICK_DIV=4, JACKPOT_TICKS=4, SCORE_W=2.
- **Reset mid-JACKPOT:** assert RESET while LEDS=1111 → immediately LEDS=0001, SCORE=0, WIN_PULSE=0. The first tick follows 4 cycles after release.
- **Idle sweep:** SWITCHES=0000 → LEDS runs 0001, 0010, 0100, 1000, 0001, each held 4 cycles. SCORE stays 0.
- **Win and blink:** raise SWITCHES[2] while LEDS=0100, before the tick →
  - WIN_PULSE is high for 1 cycle and SCORE=1;
  - LEDS shows 1111, 0000, 1111, 0000, then returns to 0001.
- **Held switch and saturation:**
  - keep SWITCHES[2] high for the next lap → no win;
  - toggle it 0→1 on three more laps → SCORE reaches 3 and then stays at 3.
- **Miss and simultaneous events:**
  - with SCORE=1, raise SWITCHES[3] while LEDS=0001 → SCORE=0;
  - repeat → SCORE stays 0;
  - raise SWITCHES[0] and SWITCHES[3] in the same tick at LEDS=0001 → win only, SCORE=1.
- **Bounce (JACKPOT_BOUNCE_EN defined):** SWITCHES=0000 → LEDS runs 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
